pll_lock_sequencer: RTL



---
 rtl/pll_seq_pkg.sv | 16 +
 rtl/sync_bit.sv | 28 ++
 rtl/pll_lock_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock sequencer: FSM state encoding and status counter width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        RST_PLL   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int STAT_W = 8;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit into the clk domain.
// Latency: STAGES clk cycles from d to q.
// Backpressure: none; samples d every cycle.
//
// Ports: clk (sampling clock), reset (sync active-high, clears chain to 0),
//        d (async input), q (synchronized output).
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset pulse, lock qualification and downstream system reset release.
// Latency: outputs are registered state decodes; lock input seen SYNC_STAGES cycles late.
// Backpressure: none; force_relock/status_clr are single-cycle requests acted on immediately.
//
// Ports: clkin (27 MHz ref, only clock), reset (sync active-high), pll_lock (async),
//        force_relock, status_clr (requests), pll_reset, sys_reset, ready (control),
//        timeout_err, retry_cnt, relock_cnt (status).
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES         = 16,
    parameter int LOCK_STABLE_CYCLES = 2700,
    parameter int LOCK_TIMEOUT       = 27000,
    parameter int SYNC_STAGES        = 2,
    parameter int CNT_W              = 16
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              pll_lock,
    input  logic              force_relock,
    input  logic              status_clr,
    output logic              pll_reset,
    output logic              sys_reset,
    output logic              ready,
    output logic              timeout_err,
    output logic [STAT_W-1:0] retry_cnt,
    output logic [STAT_W-1:0] relock_cnt
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lock_s;
    logic             timeout_evt;
    logic             loss_evt;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clkin),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Next-state and event decode. force_relock is checked first in every
    // lock-driven state so it overrides any lock transition in the same cycle.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        timeout_evt = 1'b0;
        loss_evt    = 1'b0;
        case (state)
            RST_PLL: begin
                // force_relock deliberately ignored: the pulse is never restarted.
                if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                if (force_relock) begin
                    state_nxt = RST_PLL;
                    cnt_nxt   = '0;
                end else if (lock_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt   = RST_PLL;
                    cnt_nxt     = '0;
                    timeout_evt = 1'b1;
                end
            end
            STABLE: begin
                if (force_relock) begin
                    state_nxt = RST_PLL;
                    cnt_nxt   = '0;
                end else if (!lock_s) begin
                    // Glitch: requalify from scratch without touching the PLL.
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = cnt;
                if (force_relock) begin
                    state_nxt = RST_PLL;
                    cnt_nxt   = '0;
                end else if (!lock_s) begin
                    state_nxt = RST_PLL;
                    cnt_nxt   = '0;
                    loss_evt  = 1'b1;
                end
            end
            default: begin
                state_nxt = RST_PLL;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge
    // as the state register itself.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state       <= RST_PLL;
            cnt         <= '0;
            pll_reset   <= 1'b1;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
            timeout_err <= 1'b0;
            retry_cnt   <= '0;
            relock_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pll_reset <= (state_nxt == RST_PLL);
            ready     <= (state_nxt == RUN);
            sys_reset <= (state_nxt != RUN);

            // Clear beats a coincident increment.
            if (status_clr) begin
                timeout_err <= 1'b0;
                retry_cnt   <= '0;
                relock_cnt  <= '0;
            end else begin
                if (timeout_evt) begin
                    timeout_err <= 1'b1;
                    if (retry_cnt != STAT_MAX) begin
                        retry_cnt <= retry_cnt + STAT_W'(1);
                    end
                end
                if (loss_evt && (relock_cnt != STAT_MAX)) begin
                    relock_cnt <= relock_cnt + STAT_W'(1);
                end
            end
        end
    end

endmodule
